// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP adder among N_REQ requesters.
// Each operation is bounded by a watchdog; a hung adder yields a qNaN error response.
module fp_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [32*N_REQ-1:0]  req_a_i,
    input  logic [32*N_REQ-1:0]  req_b_i,
    output logic [N_REQ-1:0]     req_ack_o,
    output logic                 fp_start_o,
    output logic [31:0]          fp_a_o,
    output logic [31:0]          fp_b_o,
    input  logic                 fp_done_i,
    input  logic [31:0]          fp_y_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [31:0]          rsp_y_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     op_count_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [N_REQ-1:0]  req_ack_q;
    logic              fp_start_q;
    logic [31:0]       fp_a_q, fp_b_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [31:0]       rsp_y_q;
    logic              rsp_err_q;
    logic              busy_q;
    logic [CNT_W-1:0]  op_count_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [TW-1:0]     timer_q;

    logic              found_d;
    logic [ID_W-1:0]   gnt_d;
    logic [ID_W-1:0]   ptr_d;
    logic [ID_W-1:0]   idx_d;

    // First pending requester at or after ptr, wrapping at N_REQ-1.
    always_comb begin
        found_d = 1'b0;
        gnt_d   = '0;
        idx_d   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_d = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!found_d && req_valid_i[idx_d]) begin
                found_d = 1'b1;
                gnt_d   = idx_d;
            end
        end
        ptr_d = (gnt_d == ID_W'(N_REQ - 1)) ? '0 : gnt_d + ID_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_ack_q   <= '0;
            fp_start_q  <= 1'b0;
            fp_a_q      <= '0;
            fp_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
            ptr_q       <= '0;
            id_q        <= '0;
            timer_q     <= '0;
        end else begin
            req_ack_q  <= '0;
            fp_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        fp_a_q     <= req_a_i[32*gnt_d +: 32];
                        fp_b_q     <= req_b_i[32*gnt_d +: 32];
                        id_q       <= gnt_d;
                        ptr_q      <= ptr_d;
                        req_ack_q  <= N_REQ'(1) << gnt_d;
                        fp_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done on the timeout edge still counts as a normal result.
                    if (fp_done_i) begin
                        rsp_y_q     <= fp_y_i;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timer_q == TW'(TIMEOUT - 2)) begin
                        rsp_y_q     <= QNAN;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack_o   = req_ack_q;
    assign fp_start_o  = fp_start_q;
    assign fp_a_o      = fp_a_q;
    assign fp_b_o      = fp_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_y_o     = rsp_y_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: requester/adder models drive stimulus,
// a negedge monitor checks grants and responses against queued expectations.
module tb_fp_add_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 64;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [N-1:0]    req_ack;
    logic            fp_start;
    logic [31:0]     fp_a, fp_b;
    logic            fp_done = 1'b0;
    logic [31:0]     fp_y = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_y;
    logic            rsp_err;
    logic            busy;
    logic [CW-1:0]   op_count;

    always #5 clk = ~clk;

    fp_add_arbiter #(.N_REQ(N), .ID_W(IW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ack_o(req_ack),
        .fp_start_o(fp_start), .fp_a_o(fp_a), .fp_b_o(fp_b),
        .fp_done_i(fp_done), .fp_y_i(fp_y),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_y_o(rsp_y), .rsp_err_o(rsp_err), .busy_o(busy), .op_count_o(op_count)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [31:0]   y;
        logic          err;
    } rsp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_g[$];
    rsp_t exp_r[$];
    logic [63:0] ops [N][8];
    int   head [N];
    int   tail [N];
    int   lat = 5;
    bit   hung = 1'b0;
    bit   force_done = 1'b0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Adder model: hand-computed single-precision sums.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1.0 + 2.0
            {32'h3FC00000, 32'h40200000}: return 32'h40800000; // 1.5 + 2.5
            {32'hBF800000, 32'h3F000000}: return 32'hBF000000; // -1.0 + 0.5
            {32'h41200000, 32'h3E800000}: return 32'h41240000; // 10 + 0.25
            {32'h40000000, 32'h40000000}: return 32'h40800000; // 2 + 2
            {32'h40400000, 32'hBF800000}: return 32'h40000000; // 3 + -1
            {32'h3F000000, 32'h3F000000}: return 32'h3F800000; // 0.5 + 0.5
            {32'h42C80000, 32'h41E00000}: return 32'h43000000; // 100 + 28
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Requesters and adder, updated just after each rising edge.
    initial begin
        int cnt;
        logic [31:0] ma, mb;
        cnt = 0; ma = '0; mb = '0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (req_ack[i] === 1'b1 && head[i] != tail[i]) head[i]++;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (head[i] != tail[i]);
                if (head[i] != tail[i]) begin
                    req_a[32*i +: 32] = ops[i][head[i]][63:32];
                    req_b[32*i +: 32] = ops[i][head[i]][31:0];
                end
            end
            fp_done = 1'b0;
            if (force_done) begin
                fp_done = 1'b1; fp_y = 32'h12345678; force_done = 1'b0;
            end else if (fp_start === 1'b1 && !hung) begin
                cnt = lat; ma = fp_a; mb = fp_b;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin fp_done = 1'b1; fp_y = fadd(ma, mb); end
            end
        end
    end

    // Monitor: grants, response stability, scoreboard pops.
    initial begin
        logic        prev_stall;
        logic [35:0] prev;
        rsp_t        e;
        int          g;
        prev_stall = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_cnt = 0; prev_stall = 1'b0;
            end else begin
                if (fp_start === 1'b1) begin
                    if (exp_g.size() == 0) chk("unexpected_start", 64'(fp_start), 64'd0);
                    else begin
                        g = exp_g.pop_front();
                        chk("grant_ack", 64'(req_ack), 64'(4'b1 << g));
                        chk("busy_at_start", 64'(busy), 64'd1);
                    end
                end else if (req_ack !== '0) begin
                    chk("ack_without_start", 64'(req_ack), 64'd0);
                end
                if (rsp_valid === 1'b1) chk("no_ack_in_resp", 64'(req_ack), 64'd0);
                if (prev_stall) chk("rsp_hold", 64'({rsp_valid, rsp_id, rsp_y, rsp_err}), 64'(prev));
                if (rsp_valid === 1'b1 && rsp_ready) begin
                    if (exp_r.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    else begin
                        e = exp_r.pop_front();
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_y", 64'(rsp_y), 64'(e.y));
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        chk("op_count_pre", 64'(op_count), 64'(exp_cnt));
                        exp_cnt++;
                    end
                end
                prev_stall = (rsp_valid === 1'b1) && !rsp_ready;
                prev = {rsp_valid, rsp_id, rsp_y, rsp_err};
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // want_rsp=0 queues only the grant (operation will be abandoned).
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] y, input bit err, input bit want_rsp);
        rsp_t r;
        ops[id][tail[id]] = {a, b};
        tail[id]++;
        exp_g.push_back(id);
        r.id = IW'(id); r.y = y; r.err = err;
        if (want_rsp) exp_r.push_back(r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        chk("rst_outputs", 64'({req_ack, fp_start, fp_a, rsp_valid, rsp_id, rsp_err, busy}), 64'd0);
        chk("rst_regs", 64'({fp_b, rsp_y}), 64'd0);
        chk("rst_count", 64'(op_count), 64'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_r.size() != 0 || exp_g.size() != 0 || rsp_valid !== 1'b0) && n < budget) begin
            @(negedge clk); n++;
        end
        if (n >= budget) chk("wait_done_timeout", 64'(exp_r.size()), 64'd0);
        tick(2);
        chk("op_count_settled", 64'(op_count), 64'(exp_cnt));
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0; ok = 1'b0;
        while (n < 50 && !ok) begin
            @(negedge clk); n++;
            if (fp_start === 1'b1) ok = 1'b1;
        end
        if (!ok) chk("wait_start_timeout", 64'(fp_start), 64'd1);
    endtask

    initial begin
        bit ok;
        int n;

        // Single requester, nominal latency.
        do_reset();
        issue(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
        wait_done(100);
        chk("count_after_one", 64'(op_count), 64'd1);

        // Sparse request pattern from reset: 1 then 3, pointer wraps to 0.
        do_reset();
        issue(1, 32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0, 1'b1);
        issue(3, 32'hBF800000, 32'h3F000000, 32'hBF000000, 1'b0, 1'b1);
        wait_done(200);

        // All four continuously valid: strict rotation from 0.
        issue(0, 32'h41200000, 32'h3E800000, 32'h41240000, 1'b0, 1'b1);
        issue(1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b1);
        issue(2, 32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 1'b1);
        issue(3, 32'h3F000000, 32'h3F000000, 32'h3F800000, 1'b0, 1'b1);
        issue(0, 32'h42C80000, 32'h41E00000, 32'h43000000, 1'b0, 1'b1);
        issue(1, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
        issue(2, 32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0, 1'b1);
        issue(3, 32'hBF800000, 32'h3F000000, 32'hBF000000, 1'b0, 1'b1);
        wait_done(400);
        chk("count_after_rotation", 64'(op_count), 64'd10);

        // Hung adder: error response exactly TIMEOUT cycles after start.
        hung = 1'b1;
        issue(1, 32'h3F000000, 32'h3F000000, 32'h7FC00000, 1'b1, 1'b1);
        wait_start(ok);
        if (ok) begin
            n = 0;
            while (n < 200 && rsp_valid !== 1'b1) begin @(negedge clk); n++; end
            chk("timeout_latency", 64'(n), 64'(TO));
        end
        wait_done(300);
        force_done = 1'b1;
        hung = 1'b0;
        tick(3);
        chk("late_done_ignored", 64'({rsp_valid, busy}), 64'd0);
        issue(2, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b1);
        wait_done(100);

        // Back-pressure: response held for 10 cycles, no new grant meanwhile.
        rsp_ready = 1'b0;
        issue(3, 32'h41200000, 32'h3E800000, 32'h41240000, 1'b0, 1'b1);
        wait_start(ok);
        issue(0, 32'h3F000000, 32'h3F000000, 32'h3F800000, 1'b0, 1'b1);
        n = 0;
        while (n < 100 && rsp_valid !== 1'b1) begin @(negedge clk); n++; end
        chk("stall_rsp_seen", 64'(rsp_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_count", 64'(op_count), 64'(exp_cnt));
        end
        tick();
        rsp_ready = 1'b1;
        wait_done(200);
        chk("count_after_stall", 64'(op_count), 64'd14);

        // Reset mid-WAIT: operation abandoned, later done ignored.
        lat = 20;
        issue(2, 32'h42C80000, 32'h41E00000, 32'h43000000, 1'b0, 1'b0);
        wait_start(ok);
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(25);
        chk("post_rst_state", 64'({rsp_valid, busy}), 64'd0);
        chk("post_rst_count", 64'(op_count), 64'd0);
        lat = 5;
        issue(1, 32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 1'b1);
        wait_done(100);
        chk("count_after_rst", 64'(op_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end
endmodule
